dijkstra_control: RTL and testbench
===================================

Name: dijkstra_control

Overview:
- Top-level sequencer for one shortest-path run.
- Initialises the distance store and the visited store, then repeats select-min / mark-visited / relax-neighbours until every node is visited or the remaining nodes are unreachable.
- Sits above the visited store (prev-vector owner), the distance store with its min-finder, and the edge-weight memory; owns every write-enable into them.

Parameters:
- MAX_NODES, 16, upper bound on graph size.
- INDEX_WIDTH, 4, node index width; must satisfy 2^INDEX_WIDTH >= MAX_NODES.
- DIST_WIDTH, 16, distance/weight width. All-ones is INFINITY, meaning no edge or not yet reached.

Ports:
- clock, input, 1, sole clock; posedge.
- reset, input, 1, asynchronous, active-high.
- start, input, 1, begin a run; sampled only in IDLE.
- number_of_nodes, input, INDEX_WIDTH, node count; latched on accepted start.
- source, input, INDEX_WIDTH, source node; latched on accepted start.
- busy, output, 1, high from accepted start until DONE exits.
- done, output, 1, one-cycle pulse at end of run.
- unreachable, output, 1, set at DONE if some node was never reached; held until next accepted start.
- vs_reset, output, 1, synchronous reset/reload pulse to the visited store.
- vs_number_of_nodes, output, INDEX_WIDTH, latched node count.
- vs_set_en, output, 1, mark-visited strobe.
- vs_index, output, INDEX_WIDTH, node being marked.
- vs_prev_node, output, INDEX_WIDTH, predecessor of the node being marked.
- vs_unvisited, input, INDEX_WIDTH, unvisited count from the visited store.
- min_req, output, 1, request to the min-finder.
- min_ack, input, 1, result valid.
- min_index, input, INDEX_WIDTH, min-finder result node.
- min_dist, input, DIST_WIDTH, distance of that node.
- min_prev, input, INDEX_WIDTH, recorded predecessor of that node.
- dist_wr_en, output, 1, distance-store write enable.
- dist_wr_index, output, INDEX_WIDTH, write address.
- dist_wr_data, output, DIST_WIDTH, distance written.
- dist_wr_prev, output, INDEX_WIDTH, predecessor written.
- edge_rd_en, output, 1, edge memory read enable.
- edge_from, output, INDEX_WIDTH, row address (current node).
- edge_to, output, INDEX_WIDTH, column address (neighbour).
- edge_weight, input, DIST_WIDTH, weight, valid the cycle after edge_rd_en.
- edge_to_dist, input, DIST_WIDTH, current distance of edge_to, valid the cycle after edge_rd_en.

Behaviour:
- Reset (async): state=IDLE; all outputs 0, including busy, done, unreachable and all strobes; latched registers 0. vs_reset is NOT driven during reset; the store is reloaded at the next run's INIT.
- IDLE: start=1 latches number_of_nodes and source, clears unreachable, asserts busy.
  - If number_of_nodes==0 or source>=number_of_nodes, go to DONE with unreachable=1.
  - Otherwise go to INIT.
- INIT, number_of_nodes+1 cycles, counter k:
  - Cycle 0: vs_reset=1; dist write index 0, INFINITY, prev 0.
  - Cycles 1..N-1: write INFINITY to index k, prev 0.
  - Final cycle: write index=source, data 0, prev=source.
  - Then go to SELECT.
- SELECT: hold min_req=1 until min_ack=1; latch min_index, min_dist and min_prev on the ack cycle; min_req drops the next cycle.
  - If min_dist==INFINITY: unreachable=1, go to DONE.
  - Else go to MARK.
- MARK, 1 cycle: vs_set_en=1, vs_index=latched min_index, vs_prev_node=latched min_prev. Then go to RELAX.
- RELAX, pipelined, N+1 cycles, counter j:
  - Issue: for j<N, edge_rd_en=1, edge_from=cur, edge_to=j.
  - Evaluate: in the cycle after each issue, for column j-1, compute cand = min_dist + edge_weight in DIST_WIDTH+1 bits.
  - Write back, same cycle, when edge_weight != INFINITY and cand < {0,edge_to_dist}: dist_wr_en=1, index j-1, data cand[DIST_WIDTH-1:0], prev=cur.
  - Self-loops and already-visited nodes need no special case; non-negative weights never improve them.
  - Then go to CHECK.
- CHECK, 1 cycle: if vs_unvisited==0, go to DONE; else go to SELECT.
- DONE, 1 cycle: done=1; busy drops the next cycle; return to IDLE.
- Write collision: INIT and RELAX never both drive dist_wr in the same cycle.
- start while busy is ignored.
- Latency for a connected graph with zero-wait min-finder: 1 + (N+1) + N·(SELECT+1+(N+1)+1) + 1 cycles.

Test Plan:
- 4-node line 0-1-2-3, weights 1/2/3, source 0 → dist_wr values 1, 3, 6 in order; vs_set_en asserted 4 times; done pulse; unreachable=0; final prev_vector {0,0,1,2}.
- 3 nodes, node 2 isolated → after two marks the min-finder returns INFINITY → done with unreachable=1; vs_set_en pulsed exactly twice.
- start with number_of_nodes=0, or source=5 with number_of_nodes=4 → done the 2nd cycle after start, unreachable=1, no vs_set_en, no dist_wr_en.
- Triangle 0→1 w=5, 0→2 w=1, 2→1 w=1 → node 1 written 5, then rewritten 2 with prev=2.
- Weight 0xFFFE with min_dist 0x0002 → cand overflows to 17 bits → no write; distance stays INFINITY.
- Assert reset mid-RELAX → outputs 0 immediately (async), state IDLE; a fresh start re-runs INIT with a vs_reset pulse and completes correctly.

Source files
------------

// File: rtl/dijkstra_control.sv
// Sequencer for one shortest-path run: initialises the distance and visited
// stores, then loops select-min / mark-visited / relax-neighbours until done.
module dijkstra_control #(
  parameter int MAX_NODES   = 16,
  parameter int INDEX_WIDTH = 4,
  parameter int DIST_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  input  logic [INDEX_WIDTH-1:0] source,
  output logic                   busy,
  output logic                   done,
  output logic                   unreachable,
  output logic                   vs_reset,
  output logic [INDEX_WIDTH-1:0] vs_number_of_nodes,
  output logic                   vs_set_en,
  output logic [INDEX_WIDTH-1:0] vs_index,
  output logic [INDEX_WIDTH-1:0] vs_prev_node,
  input  logic [INDEX_WIDTH-1:0] vs_unvisited,
  output logic                   min_req,
  input  logic                   min_ack,
  input  logic [INDEX_WIDTH-1:0] min_index,
  input  logic [DIST_WIDTH-1:0]  min_dist,
  input  logic [INDEX_WIDTH-1:0] min_prev,
  output logic                   dist_wr_en,
  output logic [INDEX_WIDTH-1:0] dist_wr_index,
  output logic [DIST_WIDTH-1:0]  dist_wr_data,
  output logic [INDEX_WIDTH-1:0] dist_wr_prev,
  output logic                   edge_rd_en,
  output logic [INDEX_WIDTH-1:0] edge_from,
  output logic [INDEX_WIDTH-1:0] edge_to,
  input  logic [DIST_WIDTH-1:0]  edge_weight,
  input  logic [DIST_WIDTH-1:0]  edge_to_dist
);

  // One extra bit so the phase counter can reach N without wrapping.
  localparam int CW = (($clog2(MAX_NODES) > INDEX_WIDTH) ? $clog2(MAX_NODES) : INDEX_WIDTH) + 1;
  localparam logic [DIST_WIDTH-1:0] INF = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SELECT, S_MARK, S_RELAX, S_CHECK, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [INDEX_WIDTH-1:0] n_q, n_d;
  logic [INDEX_WIDTH-1:0] src_q, src_d;
  logic [INDEX_WIDTH-1:0] cur_q, cur_d;
  logic [DIST_WIDTH-1:0]  dist_q, dist_d;
  logic [INDEX_WIDTH-1:0] prev_q, prev_d;
  logic                   unr_q, unr_d;

  logic                   cnt_at_n;
  logic [DIST_WIDTH:0]    cand;
  logic [INDEX_WIDTH-1:0] col_m1;

  assign cnt_at_n = (cnt_q == CW'(n_q));
  assign cand     = {1'b0, dist_q} + {1'b0, edge_weight};
  assign col_m1   = cnt_q[INDEX_WIDTH-1:0] - INDEX_WIDTH'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      src_q   <= '0;
      cur_q   <= '0;
      dist_q  <= '0;
      prev_q  <= '0;
      unr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      src_q   <= src_d;
      cur_q   <= cur_d;
      dist_q  <= dist_d;
      prev_q  <= prev_d;
      unr_q   <= unr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    n_d           = n_q;
    src_d         = src_q;
    cur_d         = cur_q;
    dist_d        = dist_q;
    prev_d        = prev_q;
    unr_d         = unr_q;
    done          = 1'b0;
    vs_reset      = 1'b0;
    vs_set_en     = 1'b0;
    vs_index      = '0;
    vs_prev_node  = '0;
    min_req       = 1'b0;
    dist_wr_en    = 1'b0;
    dist_wr_index = '0;
    dist_wr_data  = '0;
    dist_wr_prev  = '0;
    edge_rd_en    = 1'b0;
    edge_from     = '0;
    edge_to       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d   = number_of_nodes;
          src_d = source;
          unr_d = 1'b0;
          cnt_d = '0;
          if (number_of_nodes == '0 || source >= number_of_nodes) begin
            unr_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_INIT;
          end
        end
      end
      S_INIT: begin
        dist_wr_en = 1'b1;
        vs_reset   = (cnt_q == '0);
        if (cnt_at_n) begin
          dist_wr_index = src_q;
          dist_wr_data  = '0;
          dist_wr_prev  = src_q;
          cnt_d         = '0;
          state_d       = S_SELECT;
        end else begin
          dist_wr_index = cnt_q[INDEX_WIDTH-1:0];
          dist_wr_data  = INF;
          cnt_d         = cnt_q + CW'(1);
        end
      end
      S_SELECT: begin
        min_req = 1'b1;
        if (min_ack) begin
          cur_d  = min_index;
          dist_d = min_dist;
          prev_d = min_prev;
          if (min_dist == INF) begin
            unr_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_MARK;
          end
        end
      end
      S_MARK: begin
        vs_set_en    = 1'b1;
        vs_index     = cur_q;
        vs_prev_node = prev_q;
        cnt_d        = '0;
        state_d      = S_RELAX;
      end
      S_RELAX: begin
        // Issue column j while evaluating column j-1 returned by the edge memory.
        if (!cnt_at_n) begin
          edge_rd_en = 1'b1;
          edge_from  = cur_q;
          edge_to    = cnt_q[INDEX_WIDTH-1:0];
        end
        if (cnt_q != '0 && edge_weight != INF && cand < {1'b0, edge_to_dist}) begin
          dist_wr_en    = 1'b1;
          dist_wr_index = col_m1;
          dist_wr_data  = cand[DIST_WIDTH-1:0];
          dist_wr_prev  = cur_q;
        end
        if (cnt_at_n) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CHECK: begin
        state_d = (vs_unvisited == '0) ? S_DONE : S_SELECT;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy               = (state_q != S_IDLE);
  assign unreachable        = unr_q;
  assign vs_number_of_nodes = n_q;

endmodule

// File: tb/tb_dijkstra_control.sv
// Bench for dijkstra_control: behavioural stores and edge memory around the DUT,
// final distances compared against an iterative shortest-path reference.
module tb_dijkstra_control;
  localparam int IW = 4;
  localparam int DW = 16;
  localparam int MN = 16;
  localparam logic [DW-1:0] INF = '1;

  logic          clock = 1'b0;
  logic          reset, start;
  logic [IW-1:0] number_of_nodes, source;
  logic          busy, done, unreachable;
  logic          vs_reset, vs_set_en;
  logic [IW-1:0] vs_number_of_nodes, vs_index, vs_prev_node, vs_unvisited;
  logic          min_req, min_ack;
  logic [IW-1:0] min_index, min_prev;
  logic [DW-1:0] min_dist;
  logic          dist_wr_en;
  logic [IW-1:0] dist_wr_index, dist_wr_prev;
  logic [DW-1:0] dist_wr_data;
  logic          edge_rd_en;
  logic [IW-1:0] edge_from, edge_to;
  logic [DW-1:0] edge_weight, edge_to_dist;

  dijkstra_control #(.MAX_NODES(MN), .INDEX_WIDTH(IW), .DIST_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .number_of_nodes(number_of_nodes), .source(source),
    .busy(busy), .done(done), .unreachable(unreachable),
    .vs_reset(vs_reset), .vs_number_of_nodes(vs_number_of_nodes),
    .vs_set_en(vs_set_en), .vs_index(vs_index), .vs_prev_node(vs_prev_node),
    .vs_unvisited(vs_unvisited),
    .min_req(min_req), .min_ack(min_ack), .min_index(min_index),
    .min_dist(min_dist), .min_prev(min_prev),
    .dist_wr_en(dist_wr_en), .dist_wr_index(dist_wr_index),
    .dist_wr_data(dist_wr_data), .dist_wr_prev(dist_wr_prev),
    .edge_rd_en(edge_rd_en), .edge_from(edge_from), .edge_to(edge_to),
    .edge_weight(edge_weight), .edge_to_dist(edge_to_dist)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] wmat [MN][MN];
  logic [DW-1:0] dmem [MN];
  logic [IW-1:0] pmem [MN];
  logic          vis  [MN];
  logic [IW-1:0] pvec [MN];
  logic          ack_q;
  int            delay_q;
  int            n_marks = 0, n_done = 0, n_wr = 0, n_vsr = 0;
  logic [DW-1:0] wlog [$];

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MN; i++) begin
        vis[i]  <= 1'b1;
        dmem[i] <= INF;
        pmem[i] <= '0;
        pvec[i] <= '0;
      end
      ack_q   <= 1'b0;
      delay_q <= 0;
    end else begin
      if (vs_reset) begin
        for (int i = 0; i < MN; i++) vis[i] <= 1'b0;
        n_vsr++;
      end
      if (vs_set_en) begin
        vis[vs_index]  <= 1'b1;
        pvec[vs_index] <= vs_prev_node;
        n_marks++;
      end
      if (dist_wr_en) begin
        dmem[dist_wr_index] <= dist_wr_data;
        pmem[dist_wr_index] <= dist_wr_prev;
        n_wr++;
        if (dist_wr_data != INF) wlog.push_back(dist_wr_data);
      end
      if (done) n_done++;
      if (edge_rd_en) begin
        edge_weight  <= wmat[edge_from][edge_to];
        edge_to_dist <= dmem[edge_to];
      end
      if (ack_q) begin
        ack_q   <= 1'b0;
        delay_q <= int'($urandom_range(0, 2));
      end else if (min_req) begin
        if (delay_q == 0) ack_q <= 1'b1;
        else delay_q <= delay_q - 1;
      end
    end
  end

  assign min_ack = ack_q;

  always_comb begin
    logic found;
    found        = 1'b0;
    min_index    = '0;
    min_dist     = INF;
    min_prev     = '0;
    vs_unvisited = '0;
    for (int i = 0; i < MN; i++) begin
      if (i < int'(vs_number_of_nodes) && !vis[i]) begin
        vs_unvisited = vs_unvisited + IW'(1);
        if (!found || dmem[i] < min_dist) begin
          found     = 1'b1;
          min_index = IW'(i);
          min_dist  = dmem[i];
          min_prev  = pmem[i];
        end
      end
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clear_w();
    for (int u = 0; u < MN; u++)
      for (int v = 0; v < MN; v++) wmat[u][v] = INF;
  endtask

  task automatic set_line();
    clear_w();
    wmat[0][1] = 1; wmat[1][0] = 1;
    wmat[1][2] = 2; wmat[2][1] = 2;
    wmat[2][3] = 3; wmat[3][2] = 3;
  endtask

  int run_marks, run_w0, run_vsr, run_wr;

  task automatic run_graph(input int n, input int src, input bit poke);
    int m0, d0, r0, c0, cyc;
    m0 = n_marks; d0 = n_done; r0 = n_vsr; c0 = n_wr; run_w0 = wlog.size();
    @(negedge clock);
    number_of_nodes = IW'(n); source = IW'(src); start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (n_done == d0 && cyc < 4000) begin
      if (poke && cyc == 5) begin number_of_nodes = IW'(1); source = '0; start = 1'b1; end
      if (poke && cyc == 6) start = 1'b0;
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    chk($sformatf("done_pulse n=%0d", n), n_done - d0, 1);
    chk("busy_after_done", busy, 0);
    chk("done_low_after", done, 0);
    run_marks = n_marks - m0;
    run_vsr   = n_vsr - r0;
    run_wr    = n_wr - c0;
  endtask

  logic [DW-1:0] refd [MN];

  task automatic verify(input int n, input int src, input string tag);
    logic [DW:0] c;
    int reach;
    bit any_unr;
    for (int i = 0; i < MN; i++) refd[i] = INF;
    refd[src] = '0;
    for (int it = 0; it < n; it++)
      for (int u = 0; u < n; u++)
        for (int v = 0; v < n; v++)
          if (refd[u] != INF && wmat[u][v] != INF) begin
            c = {1'b0, refd[u]} + {1'b0, wmat[u][v]};
            if (c < {1'b0, refd[v]}) refd[v] = c[DW-1:0];
          end
    reach = 0; any_unr = 1'b0;
    for (int v = 0; v < n; v++) begin
      chk($sformatf("%s dist[%0d]", tag, v), 32'(dmem[v]), 32'(refd[v]));
      if (refd[v] != INF) reach++;
      else any_unr = 1'b1;
    end
    chk({tag, " unreachable"}, unreachable, 32'(any_unr));
    chk({tag, " marks"}, run_marks, reach);
    chk({tag, " vs_reset_pulses"}, run_vsr, 1);
    chk({tag, " prev_src"}, 32'(pvec[src]), src);
    for (int v = 0; v < n; v++)
      if (v != src && refd[v] != INF) begin
        c = {1'b0, refd[pvec[v]]} + {1'b0, wmat[pvec[v]][v]};
        chk($sformatf("%s prev_ok[%0d]", tag, v), 32'(c), 32'(refd[v]));
      end
  endtask

  initial begin
    int n, src, cyc, mw0;
    reset = 1'b1; start = 1'b0; number_of_nodes = '0; source = '0;
    repeat (3) @(negedge clock);
    chk("reset_ctrl", {busy, done, unreachable, vs_reset, vs_set_en, min_req, dist_wr_en, edge_rd_en}, 0);
    chk("reset_vs_n", vs_number_of_nodes, 0);
    reset = 1'b0;
    @(negedge clock);

    // Invalid starts: done on the second cycle, nothing written.
    for (int t = 0; t < 2; t++) begin
      mw0 = n_wr; n = n_marks;
      number_of_nodes = (t == 0) ? IW'(0) : IW'(4);
      source          = (t == 0) ? IW'(0) : IW'(5);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("bad_done_cyc", done, 1);
      chk("bad_busy", busy, 1);
      chk("bad_unreach", unreachable, 1);
      @(negedge clock);
      chk("bad_done_drop", done, 0);
      chk("bad_busy_drop", busy, 0);
      chk("bad_unreach_hold", unreachable, 1);
      chk("bad_no_marks", n_marks - n, 0);
      chk("bad_no_writes", n_wr - mw0, 0);
    end

    set_line();
    run_graph(4, 0, 1'b0);
    verify(4, 0, "line");
    chk("line_wr_count", wlog.size() - run_w0, 4);
    chk("line_wr0", 32'(wlog[run_w0]), 0);
    chk("line_wr1", 32'(wlog[run_w0 + 1]), 1);
    chk("line_wr2", 32'(wlog[run_w0 + 2]), 3);
    chk("line_wr3", 32'(wlog[run_w0 + 3]), 6);
    chk("line_prev", {16'd0, pvec[0], pvec[1], pvec[2], pvec[3]}, 32'h0012);

    clear_w();
    wmat[0][1] = 4; wmat[1][0] = 4;
    run_graph(3, 0, 1'b0);
    verify(3, 0, "isolated");
    chk("iso_marks", run_marks, 2);

    clear_w();
    wmat[0][1] = 5; wmat[0][2] = 1; wmat[2][1] = 1;
    run_graph(3, 0, 1'b1);
    verify(3, 0, "triangle");
    chk("tri_wr_count", wlog.size() - run_w0, 4);
    chk("tri_wr1", 32'(wlog[run_w0 + 1]), 5);
    chk("tri_wr3", 32'(wlog[run_w0 + 3]), 2);
    chk("tri_prev1", 32'(pmem[1]), 2);

    clear_w();
    wmat[0][1] = 2; wmat[1][2] = 16'hFFFE;
    run_graph(3, 0, 1'b0);
    verify(3, 0, "overflow");
    chk("ovf_dist2", 32'(dmem[2]), 32'(INF));

    for (int g = 0; g < 6; g++) begin
      n   = int'($urandom_range(2, 8));
      src = int'($urandom_range(0, n - 1));
      clear_w();
      for (int u = 0; u < n; u++)
        for (int v = 0; v < n; v++)
          if ($urandom_range(0, 99) < 40) wmat[u][v] = DW'($urandom_range(0, 20));
      run_graph(n, src, 1'b0);
      verify(n, src, $sformatf("rand%0d", g));
    end

    // Reset asserted between clock edges while relaxing.
    set_line();
    @(negedge clock);
    number_of_nodes = IW'(4); source = '0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (!edge_rd_en && cyc < 200) begin @(negedge clock); cyc++; end
    chk("reach_relax", edge_rd_en, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_ctrl", {busy, done, unreachable, vs_set_en, min_req, dist_wr_en, edge_rd_en, vs_reset}, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    run_graph(4, 0, 1'b0);
    verify(4, 0, "after_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
